sram_arb_seq: RTL and testbench

Two-port arbiter and cycle sequencer for the external 512K x 8 asynchronous SRAM. It sits between the SRAM pins and two clk-domain requesters. Port 0 is the SPI local-bus side, already synchronized into clk. Port 1 is the internal fabric user (capture or DMA engine). The block grants the SRAM round-robin, runs a fixed-length read or write cycle with programmable wait states, owns the data-bus tristate enable, and returns a one-cycle acknowledge with registered read data.

---
 rtl/sram_arb_seq_if.sv | 36 +++
 rtl/sram_arb_seq.sv | 162 ++++++++++++++++
 tb/tb_sram_arb_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_seq_if.sv
// Bundled request/acknowledge and SRAM pad signals for sram_arb_seq.
// The master side is the requesters plus the SRAM pad; the slave side is the arbiter.
interface sram_arb_seq_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [18:0] addr0;
  logic [18:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic        ack0;
  logic        ack1;
  logic [7:0]  rdata0;
  logic [7:0]  rdata1;
  logic        busy;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i;
  logic        sram_cen;
  logic        sram_oen;
  logic        sram_wen;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_i,
    input  ack0, ack1, rdata0, rdata1, busy,
           sram_addr, sram_dq_o, sram_dq_oe, sram_cen, sram_oen, sram_wen
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_i,
    output ack0, ack1, rdata0, rdata1, busy,
           sram_addr, sram_dq_o, sram_dq_oe, sram_cen, sram_oen, sram_wen
  );
endinterface

// File: rtl/sram_arb_seq.sv
// Round-robin two-port arbiter and fixed-length cycle sequencer for a 512K x 8
// asynchronous SRAM; every pad and handshake output comes straight from a flop.
module sram_arb_seq #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arb_seq_if.slave bus
);

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    TURN    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        gnt_r, gnt_s;
  logic        last_r, last_s;
  logic [18:0] addr_r, addr_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        pick_s;
  logic        rd_s, wr_s, hold_s, active_s, oe_s;

  logic        ack0_r, ack1_r, busy_r;
  logic [7:0]  rdata0_r, rdata1_r;
  logic [18:0] sram_addr_r;
  logic [7:0]  sram_dq_o_r;
  logic        sram_dq_oe_r, sram_cen_r, sram_oen_r, sram_wen_r;

  // Next-state, grant selection and access latching.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt_r;
    last_s  = last_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    if (bus.req0 && bus.req1) begin
      pick_s = ~last_r;
    end else begin
      pick_s = bus.req1;
    end
    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_s   = pick_s;
          last_s  = pick_s;
          addr_s  = pick_s ? bus.addr1 : bus.addr0;
          wdata_s = pick_s ? bus.wdata1 : bus.wdata0;
          cnt_s   = 4'd1;
          if (pick_s ? bus.we1 : bus.we0) begin
            state_s = WR;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (cnt_r == RD_LAST) begin
          state_s = TURN;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      WR: begin
        if (cnt_r == WR_LAST) begin
          state_s = WR_HOLD;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      WR_HOLD: state_s = TURN;
      TURN:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Decode of the upcoming state used to preload the output flops.
  always_comb begin
    rd_s     = (state_s == RD);
    wr_s     = (state_s == WR);
    hold_s   = (state_s == WR_HOLD);
    active_s = rd_s | wr_s | hold_s;
    oe_s     = wr_s | hold_s;
  end

  // State and latched access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      addr_r  <= 19'd0;
      wdata_r <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Registered pad strobes, handshake and read-data capture (sampled while OEn is still low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen_r   <= 1'b1;
      sram_oen_r   <= 1'b1;
      sram_wen_r   <= 1'b1;
      sram_dq_oe_r <= 1'b0;
      sram_addr_r  <= 19'd0;
      sram_dq_o_r  <= 8'd0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
      rdata0_r     <= 8'd0;
      rdata1_r     <= 8'd0;
    end else begin
      sram_cen_r   <= ~active_s;
      sram_oen_r   <= ~rd_s;
      sram_wen_r   <= ~wr_s;
      sram_dq_oe_r <= oe_s;
      sram_addr_r  <= active_s ? addr_s : 19'd0;
      sram_dq_o_r  <= oe_s ? wdata_s : 8'd0;
      ack0_r       <= (state_s == TURN) && !gnt_s;
      ack1_r       <= (state_s == TURN) && gnt_s;
      busy_r       <= (state_s != IDLE);
      if ((state_r == RD) && (state_s == TURN)) begin
        if (gnt_r) begin
          rdata1_r <= bus.sram_dq_i;
        end else begin
          rdata0_r <= bus.sram_dq_i;
        end
      end
    end
  end

  assign bus.ack0       = ack0_r;
  assign bus.ack1       = ack1_r;
  assign bus.busy       = busy_r;
  assign bus.rdata0     = rdata0_r;
  assign bus.rdata1     = rdata1_r;
  assign bus.sram_addr  = sram_addr_r;
  assign bus.sram_dq_o  = sram_dq_o_r;
  assign bus.sram_dq_oe = sram_dq_oe_r;
  assign bus.sram_cen   = sram_cen_r;
  assign bus.sram_oen   = sram_oen_r;
  assign bus.sram_wen   = sram_wen_r;

endmodule

// File: tb/tb_sram_arb_seq.sv
// Bench for sram_arb_seq: directed cases plus random traffic, checked every cycle
// against a transaction-timeline reference model and a behavioural SRAM.
module tb_sram_arb_seq;
  localparam int RDW = 2;
  localparam int WRW = 3;

  logic clk;
  logic rst_n;
  sram_arb_seq_if bus();

  sram_arb_seq #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [18:0] addr_v [2];
  logic [7:0]  wdata_v [2];
  assign bus.req0   = req_v[0];
  assign bus.req1   = req_v[1];
  assign bus.we0    = we_v[0];
  assign bus.we1    = we_v[1];
  assign bus.addr0  = addr_v[0];
  assign bus.addr1  = addr_v[1];
  assign bus.wdata0 = wdata_v[0];
  assign bus.wdata1 = wdata_v[1];

  logic [7:0] mem [0:524287];
  logic [7:0] ref_mem [0:524287];
  assign bus.sram_dq_i = (!bus.sram_cen && !bus.sram_oen) ? mem[bus.sram_addr] : 8'h00;

  always @(posedge bus.sram_wen) begin
    if (bus.sram_cen === 1'b0) mem[bus.sram_addr] <= bus.sram_dq_o;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction described by its grant cycle.
  logic        m_active;
  int          m_s;
  logic        m_p, m_we, m_last;
  logic [18:0] m_a;
  logic [7:0]  m_d;
  logic [7:0]  exp_rd [2];
  logic [1:0]  ack_now;

  logic        auto_mode;
  logic [1:0]  rereq;
  int          ack_cyc [2];
  int          ack_log [$];
  int          n_rd_low, n_wen_low, n_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int txn_len(input logic we);
    return we ? (WRW + 3) : (RDW + 2);
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_last    = 1'b1;
    m_s       = 0;
    m_we      = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    req_v     = 2'b00;
  endtask

  task automatic check_cycle();
    int k;
    logic e_cen, e_oen, e_wen, e_oe, e_busy;
    logic [18:0] e_addr;
    logic [1:0]  e_ack;
    e_cen = 1'b1; e_oen = 1'b1; e_wen = 1'b1; e_oe = 1'b0; e_busy = 1'b0;
    e_addr = 19'd0; e_ack = 2'b00; ack_now = 2'b00;
    k = cyc - m_s;
    if (m_active && k >= 1 && k < txn_len(m_we)) begin
      e_busy = 1'b1;
      if (k == txn_len(m_we) - 1) begin
        e_ack[m_p]   = 1'b1;
        ack_now[m_p] = 1'b1;
        if (m_we) ref_mem[m_a] = m_d;
        else exp_rd[m_p] = ref_mem[m_a];
      end else begin
        e_cen  = 1'b0;
        e_addr = m_a;
        if (m_we) begin
          e_oe  = 1'b1;
          e_wen = (k <= WRW) ? 1'b0 : 1'b1;
        end else begin
          e_oen = 1'b0;
        end
      end
    end
    check_val("strobes", {28'd0, bus.sram_cen, bus.sram_oen, bus.sram_wen, bus.sram_dq_oe},
              {28'd0, e_cen, e_oen, e_wen, e_oe});
    check_val("sram_addr", {13'd0, bus.sram_addr}, {13'd0, e_addr});
    if (e_oe) check_val("dq_o", {24'd0, bus.sram_dq_o}, {24'd0, m_d});
    check_val("ack", {30'd0, bus.ack1, bus.ack0}, {30'd0, e_ack});
    check_val("busy", {31'd0, bus.busy}, {31'd0, e_busy});
    check_val("rdata0", {24'd0, bus.rdata0}, {24'd0, exp_rd[0]});
    check_val("rdata1", {24'd0, bus.rdata1}, {24'd0, exp_rd[1]});
    check_val("oen_wen_low", {31'd0, !bus.sram_oen && !bus.sram_wen}, 32'd0);
    check_val("oe_while_oen", {31'd0, !bus.sram_oen && bus.sram_dq_oe}, 32'd0);
    check_val("addr_idle", bus.sram_cen ? {13'd0, bus.sram_addr} : 32'd0, 32'd0);
    check_val("dual_ack", {31'd0, bus.ack0 && bus.ack1}, 32'd0);
  endtask

  task automatic new_req(input int p);
    req_v[p] = 1'b1;
    we_v[p]  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) addr_v[p] = 19'h7FFFF;
    else addr_v[p] = 19'($urandom_range(0, 15));
    wdata_v[p] = 8'($urandom_range(0, 255));
  endtask

  task automatic grant();
    logic p;
    if (rst_n && (!m_active || (cyc - m_s) >= txn_len(m_we)) && (req_v != 2'b00)) begin
      p = (req_v == 2'b11) ? ~m_last : req_v[1];
      m_last   = p;
      m_active = 1'b1;
      m_s      = cyc;
      m_p      = p;
      m_we     = we_v[p];
      m_a      = addr_v[p];
      m_d      = wdata_v[p];
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
    if (bus.ack0) begin ack_cyc[0] = cyc; ack_log.push_back(0); end
    if (bus.ack1) begin ack_cyc[1] = cyc; ack_log.push_back(1); end
    if (!bus.sram_cen && !bus.sram_oen) n_rd_low++;
    if (!bus.sram_wen) n_wen_low++;
    if (!bus.sram_cen && bus.sram_wen && bus.sram_dq_oe) n_hold++;
    for (int p = 0; p < 2; p++) begin
      if (ack_now[p]) begin
        if (auto_mode && ($urandom_range(0, 1) == 1)) new_req(p);
        else if (!rereq[p]) req_v[p] = 1'b0;
      end else if (auto_mode && !req_v[p] && ($urandom_range(0, 3) == 0)) begin
        new_req(p);
      end
    end
    grant();
  endtask

  task automatic clear_obs();
    ack_cyc[0] = -1; ack_cyc[1] = -1;
    ack_log.delete();
    n_rd_low = 0; n_wen_low = 0; n_hold = 0;
  endtask

  task automatic wait_ack(input int p, input string tag);
    for (int i = 0; i < 30 && ack_cyc[p] < 0; i++) step();
    check_val(tag, {31'd0, ack_cyc[p] >= 0}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 524288; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[19'h1234A] = 8'h5C;
    ref_mem[19'h1234A] = 8'h5C;
    req_v = 2'b00; we_v = 2'b00;
    addr_v[0] = 19'd0; addr_v[1] = 19'd0; wdata_v[0] = 8'd0; wdata_v[1] = 8'd0;
    auto_mode = 1'b0; rereq = 2'b00;
    rst_n = 1'b1;
    model_reset();
    clear_obs();
    #3 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();

    // Single port-0 read.
    clear_obs();
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 19'h1234A;
    grant();
    g = cyc;
    wait_ack(0, "rd_done");
    check_val("rd_ack_cycle", 32'(ack_cyc[0] - g), 32'd3);
    check_val("rd_strobe_cycles", 32'(n_rd_low), 32'd2);
    check_val("rd_rdata0", {24'd0, bus.rdata0}, 32'h5C);
    check_val("rd_rdata1_kept", {24'd0, bus.rdata1}, 32'h00);
    step();

    // Single port-1 write.
    clear_obs();
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 19'h7FFFF; wdata_v[1] = 8'hA5;
    grant();
    g = cyc;
    wait_ack(1, "wr_done");
    check_val("wr_ack_cycle", 32'(ack_cyc[1] - g), 32'd5);
    check_val("wr_wen_cycles", 32'(n_wen_low), 32'd3);
    check_val("wr_hold_cycles", 32'(n_hold), 32'd1);
    check_val("wr_sram_cell", {24'd0, mem[19'h7FFFF]}, 32'hA5);
    step();

    // Contention out of reset: both ports keep re-requesting reads.
    do_reset();
    clear_obs();
    rereq = 2'b11;
    we_v = 2'b00; addr_v[0] = 19'h00003; addr_v[1] = 19'h1234A;
    req_v = 2'b11;
    grant();
    for (int i = 0; i < 60 && ack_log.size() < 4; i++) step();
    check_val("cont_acks", 32'(ack_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check_val("cont_order", 32'(ack_log[i]), 32'(i % 2));
    rereq = 2'b00;
    for (int i = 0; i < 30 && (req_v != 2'b00 || bus.busy); i++) step();

    // Reset in the second write cycle.
    clear_obs();
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 19'h40000; wdata_v[1] = 8'h3C;
    grant();
    for (int i = 0; i < 20 && !(m_active && m_we && (cyc - m_s) == 2); i++) step();
    check_val("midwr_reached", {31'd0, bus.sram_wen}, 32'd0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("midwr_wen", {31'd0, bus.sram_wen}, 32'd1);
    check_val("midwr_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
    check_val("midwr_cen", {31'd0, bus.sram_cen}, 32'd1);
    check_val("midwr_busy", {31'd0, bus.busy}, 32'd0);
    check_val("midwr_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    clear_obs();
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 19'h7FFFF;
    grant();
    wait_ack(1, "post_rst_done");
    check_val("post_rst_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) check_val("post_rst_port", 32'(ack_log[0]), 32'd1);
    check_val("post_rst_rdata1", {24'd0, bus.rdata1}, 32'hA5);

    // Random traffic.
    auto_mode = 1'b1;
    repeat (10000) step();
    auto_mode = 1'b0;
    for (int i = 0; i < 40 && (req_v != 2'b00 || bus.busy); i++) step();
    check_val("drained", {30'd0, req_v}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
